// File: rtl/mem_arb_pkg.sv
// Purpose : shared types and defaults for the main memory arbiter slice.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      ARB  = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } arb_state_t;

   localparam int REQ_CPU       = 0;
   localparam int REQ_LDR       = 1;
   localparam int DATA_W_DEF    = 32;
   localparam int ADDR_W_DEF    = 8;
   localparam int BURST_MAX_DEF = 4;

endpackage

// File: rtl/rr_pick2.sv
// Purpose : 2-way round-robin picker; on a tie the requester that was not served last wins.
// Latency : purely combinational.
// Backpressure: none; grant follows request in the same cycle.
// Ports   : req[1:0] requests, last = index served most recently, gnt[1:0] one-hot grant.
module rr_pick2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = 2'b00;
      if (req[0] && (!req[1] || last)) begin
         gnt = 2'b01;
      end else if (req[1]) begin
         gnt = 2'b10;
      end
   end

endmodule

// File: rtl/main_mem_arbiter.sv
// Purpose : shares single-port main memory between cpu (req 0) and loader (req 1), RR + bounded lock.
// Latency : grant/memory strobe combinational; read data valid 1 cycle after accepted read.
// Backpressure: requester holds req until gnt; a locked owner is cut off after BURST_MAX grants.
// Ports   : clk/rst (sync, active-high); per requester req/we/addr/wdata/lock in, gnt/rvalid/rdata out;
//           mem_en/mem_we/mem_addr/mem_wdata to the memory, mem_rdata back from it.
module main_mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int BURST_MAX = BURST_MAX_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic              we0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   input  logic              lock0,
   output logic              gnt0,
   output logic              rvalid0,
   output logic [DATA_W-1:0] rdata0,
   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   input  logic              lock1,
   output logic              gnt1,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata1,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int CNT_W = $clog2(BURST_MAX + 1);

   arb_state_t       state, state_nxt;
   logic             last, last_nxt;
   logic [CNT_W-1:0] burst_cnt, burst_cnt_nxt;
   logic [CNT_W-1:0] cnt_sat;
   logic [1:0]       rr_gnt;
   logic [1:0]       gnt_v;
   logic             owned;
   logic             sel;
   logic             lock_sel;
   logic             other_req;
   logic             rvalid0_q, rvalid1_q;

   rr_pick2 u_pick (
      .req  ({req1, req0}),
      .last (last),
      .gnt  (rr_gnt)
   );

   // Owner keeps the port only while it is still requesting; otherwise fall
   // through to plain round-robin in the same cycle.
   assign owned = (state == OWN0 && req0) || (state == OWN1 && req1);
   assign cnt_sat = (burst_cnt == CNT_W'(BURST_MAX)) ? burst_cnt : burst_cnt + CNT_W'(1);

   always_comb begin
      gnt_v         = 2'b00;
      state_nxt     = state;
      last_nxt      = last;
      burst_cnt_nxt = burst_cnt;
      sel           = 1'b0;
      lock_sel      = 1'b0;
      other_req     = 1'b0;

      if (state == OWN0 && req0) begin
         gnt_v = 2'b01;
      end else if (state == OWN1 && req1) begin
         gnt_v = 2'b10;
      end else begin
         gnt_v = rr_gnt;
      end
      if (rst) begin
         gnt_v = 2'b00;
      end

      sel       = gnt_v[1];
      lock_sel  = sel ? lock1 : lock0;
      other_req = sel ? req0 : req1;

      if (|gnt_v) begin
         last_nxt = sel;
         if (owned) begin
            // cnt_sat includes the grant being accepted now, so the owner
            // gets exactly BURST_MAX consecutive grants while the other waits.
            if (lock_sel && (cnt_sat < CNT_W'(BURST_MAX) || !other_req)) begin
               burst_cnt_nxt = cnt_sat;
            end else begin
               state_nxt     = ARB;
               burst_cnt_nxt = '0;
            end
         end else if (lock_sel) begin
            state_nxt     = sel ? OWN1 : OWN0;
            burst_cnt_nxt = CNT_W'(1);
         end else begin
            state_nxt     = ARB;
            burst_cnt_nxt = '0;
         end
      end else begin
         state_nxt     = ARB;
         burst_cnt_nxt = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ARB;
         last      <= 1'b1;
         burst_cnt <= '0;
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
      end else begin
         state     <= state_nxt;
         last      <= last_nxt;
         burst_cnt <= burst_cnt_nxt;
         rvalid0_q <= gnt_v[0] & ~we0;
         rvalid1_q <= gnt_v[1] & ~we1;
      end
   end

   assign gnt0 = gnt_v[0];
   assign gnt1 = gnt_v[1];

   // A read accepted just before reset would otherwise surface its pulse
   // during the reset cycle.
   assign rvalid0 = rvalid0_q & ~rst;
   assign rvalid1 = rvalid1_q & ~rst;
   assign rdata0  = mem_rdata;
   assign rdata1  = mem_rdata;

   assign mem_en    = |gnt_v;
   assign mem_we    = gnt_v[0] ? we0    : (gnt_v[1] ? we1    : 1'b0);
   assign mem_addr  = gnt_v[0] ? addr0  : (gnt_v[1] ? addr1  : '0);
   assign mem_wdata = gnt_v[0] ? wdata0 : (gnt_v[1] ? wdata1 : '0);

endmodule
